// File: rtl/aes_key_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : aes_key_scheduler                                       |
// | Purpose  : sequential AES key expansion (one word per clock) with  |
// |            an indexed 128-bit round-key read port                  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module aes_key_scheduler #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NK*32-1:0] key,
  output logic             busy,
  output logic             ready,
  output logic             done,
  input  logic             rk_req,
  input  logic [3:0]       rk_idx,
  output logic             rk_valid,
  output logic [127:0]     rk_out,
  output logic             rk_err
);

  localparam int TOTAL  = 4 * (NR + 1);
  localparam int ADDR_W = $clog2(TOTAL);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_READY  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       win_q [NK];
  logic [31:0]       win_d [NK];
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [2:0]        mod_q, mod_d;
  logic [7:0]        rcon_q, rcon_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              rk_valid_q, rk_valid_d;
  logic              rk_err_q, rk_err_d;
  logic [127:0]      rk_out_q, rk_out_d;

  logic [31:0]       mem [TOTAL];

  logic [31:0]       temp, sw_in, sw_out, new_word;
  logic              rd_ok;
  logic [ADDR_W-1:0] rd_base;

  // Entry x of the table sits at bit offset 8*(255-x), i.e. {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  // win_q holds the sliding window w[i-NK] .. w[i-1]; the single SubWord unit
  // is shared between the RotWord step and the extra AES-256 step.
  always_comb begin
    temp   = win_q[NK-1];
    sw_in  = (mod_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    sw_out = {sbox(sw_in[31:24]), sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0])};
    if (mod_q == 3'd0) begin
      new_word = win_q[0] ^ sw_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && mod_q == 3'd4) begin
      new_word = win_q[0] ^ sw_out;
    end else begin
      new_word = win_q[0] ^ temp;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    mod_d   = mod_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (start) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          for (int j = 0; j < NK; j++) begin
            win_d[j] = key[(NK-j)*32-1 -: 32];
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_EXPAND;
        idx_d   = ADDR_W'(NK);
        mod_d   = 3'd0;
        rcon_d  = 8'h01;
      end
      ST_EXPAND: begin
        for (int j = 0; j < NK - 1; j++) begin
          win_d[j] = win_q[j+1];
        end
        win_d[NK-1] = new_word;
        idx_d       = idx_q + ADDR_W'(1);
        mod_d       = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (idx_q == ADDR_W'(TOTAL - 1)) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read port sees ready_q, so a request alongside a rekey start is still
  // served from the old schedule before LOAD overwrites the buffer.
  always_comb begin
    rd_ok      = rk_req && ready_q && (rk_idx <= 4'(NR));
    rd_base    = ADDR_W'({rk_idx, 2'b00});
    rk_valid_d = rd_ok;
    rk_err_d   = rk_req && !rd_ok;
    rk_out_d   = rk_out_q;
    if (rd_ok) begin
      rk_out_d = {mem[rd_base], mem[rd_base + ADDR_W'(1)],
                  mem[rd_base + ADDR_W'(2)], mem[rd_base + ADDR_W'(3)]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      mod_q      <= '0;
      rcon_q     <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      rk_out_q   <= '0;
      for (int j = 0; j < NK; j++) begin
        win_q[j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      idx_q      <= idx_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rk_valid_q <= rk_valid_d;
      rk_err_q   <= rk_err_d;
      rk_out_q   <= rk_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_LOAD) begin
        for (int j = 0; j < NK; j++) begin
          mem[ADDR_W'(j)] <= win_q[j];
        end
      end else if (state_q == ST_EXPAND) begin
        mem[idx_q] <= new_word;
      end
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign done     = done_q;
  assign rk_valid = rk_valid_q;
  assign rk_err   = rk_err_q;
  assign rk_out   = rk_out_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_aes_key_scheduler                                    |
// | Purpose  : self-checking bench for aes_key_scheduler (NK=4/6/8)    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_aes_key_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index k: 0 -> AES-128, 1 -> AES-192, 2 -> AES-256
  logic         start_s [3];
  logic         req_s   [3];
  logic [3:0]   idx_s   [3];
  logic         busy_s  [3];
  logic         ready_s [3];
  logic         done_s  [3];
  logic         valid_s [3];
  logic         err_s   [3];
  logic [127:0] out_s   [3];
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  int e0     = 0;

  logic [7:0]  sbox_m [256];
  logic [31:0] exp_w  [3][60];

  aes_key_scheduler #(.NK(4), .NR(10)) u_nk4 (
    .clk(clk), .rst(rst), .start(start_s[0]), .key(key4),
    .busy(busy_s[0]), .ready(ready_s[0]), .done(done_s[0]),
    .rk_req(req_s[0]), .rk_idx(idx_s[0]), .rk_valid(valid_s[0]),
    .rk_out(out_s[0]), .rk_err(err_s[0]));

  aes_key_scheduler #(.NK(6), .NR(12)) u_nk6 (
    .clk(clk), .rst(rst), .start(start_s[1]), .key(key6),
    .busy(busy_s[1]), .ready(ready_s[1]), .done(done_s[1]),
    .rk_req(req_s[1]), .rk_idx(idx_s[1]), .rk_valid(valid_s[1]),
    .rk_out(out_s[1]), .rk_err(err_s[1]));

  aes_key_scheduler #(.NK(8), .NR(14)) u_nk8 (
    .clk(clk), .rst(rst), .start(start_s[2]), .key(key8),
    .busy(busy_s[2]), .ready(ready_s[2]), .done(done_s[2]),
    .rk_req(req_s[2]), .rk_idx(idx_s[2]), .rk_valid(valid_s[2]),
    .rk_out(out_s[2]), .rk_err(err_s[2]));

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // kv is left-aligned: w[0] always in kv[255:224].
  task automatic model_expand(input int k, input logic [255:0] kv);
    int nk, nr;
    logic [31:0] t;
    logic [7:0]  rc;
    nk = 4 + 2 * k;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) exp_w[k][i] = kv[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = exp_w[k][i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      exp_w[k][i] = exp_w[k][i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rk_model(input int k, input int r);
    return {exp_w[k][4*r], exp_w[k][4*r+1], exp_w[k][4*r+2], exp_w[k][4*r+3]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic set_key(input int k, input logic [255:0] kv);
    case (k)
      0:       key4 = kv[255:128];
      1:       key6 = kv[255:64];
      default: key8 = kv;
    endcase
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_start(input int k, input logic [255:0] kv);
    set_key(k, kv);
    start_s[k] = 1'b1;
    tick();
    start_s[k] = 1'b0;
    e0 = ecnt;
  endtask

  task automatic wait_ready(input int k);
    int nk, exp_e, guard;
    nk    = 4 + 2 * k;
    exp_e = 4 * (nk + 7) - nk + 1;
    guard = 0;
    while (ready_s[k] !== 1'b1 && guard < 200) begin
      checks++;
      if (busy_s[k] !== 1'b1) begin
        errors++;
        $display("FAIL busy_during_expand k=%0d E%0d: got %b want 1", k, ecnt - e0, busy_s[k]);
      end
      tick();
      guard++;
    end
    checks++;
    if (ecnt - e0 !== exp_e) begin
      errors++;
      $display("FAIL ready_edge k=%0d: got E%0d want E%0d", k, ecnt - e0, exp_e);
    end
    checks++;
    if (done_s[k] !== 1'b1 || busy_s[k] !== 1'b0) begin
      errors++;
      $display("FAIL done_at_ready k=%0d: got done=%b busy=%b want done=1 busy=0", k, done_s[k], busy_s[k]);
    end
    tick();
    checks++;
    if (done_s[k] !== 1'b0 || ready_s[k] !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse k=%0d: got done=%b ready=%b want done=0 ready=1", k, done_s[k], ready_s[k]);
    end
  endtask

  task automatic read_one(input int k, input int r, output logic [127:0] o, output logic v, output logic e);
    req_s[k] = 1'b1;
    idx_s[k] = 4'(r);
    tick();
    req_s[k] = 1'b0;
    o = out_s[k];
    v = valid_s[k];
    e = err_s[k];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy_s[k], ready_s[k], done_s[k], valid_s[k], err_s[k], out_s[k]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs k=%0d: got busy=%b ready=%b done=%b valid=%b err=%b out=%h want all 0",
                 k, busy_s[k], ready_s[k], done_s[k], valid_s[k], err_s[k], out_s[k]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_all(input int k);
    int nr;
    nr = 4 + 2 * k + 6;
    for (int r = 0; r <= nr; r++) begin
      req_s[k] = 1'b1;
      idx_s[k] = 4'(r);
      tick();
      checks++;
      if (valid_s[k] !== 1'b1 || out_s[k] !== rk_model(k, r)) begin
        errors++;
        $display("FAIL round_key k=%0d r=%0d: got valid=%b %h want valid=1 %h", k, r, valid_s[k], out_s[k], rk_model(k, r));
      end
    end
    req_s[k] = 1'b0;
    tick();
    checks++;
    if (valid_s[k] !== 1'b0 || err_s[k] !== 1'b0) begin
      errors++;
      $display("FAIL idle_read k=%0d: got valid=%b err=%b want 0 0", k, valid_s[k], err_s[k]);
    end
  endtask

  task automatic test_known_vectors();
    logic [255:0] kv;
    logic [127:0] o;
    logic v, e;
    logic [127:0] want [3];
    int           rr   [3];
    kv = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    model_expand(0, kv);
    do_start(0, kv);
    wait_ready(0);
    read_one(0, 0, o, v, e);
    checks++;
    if (v !== 1'b1 || o !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++;
      $display("FAIL aes128_round0: got valid=%b %h want key", v, o);
    end
    read_one(0, 1, o, v, e);
    checks++;
    if (v !== 1'b1 || o !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++;
      $display("FAIL aes128_round1: got valid=%b %h want a0fafe1788542cb123a339392a6c7605", v, o);
    end
    kv = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    model_expand(1, kv);
    do_start(1, kv);
    wait_ready(1);
    kv = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    model_expand(2, kv);
    do_start(2, kv);
    wait_ready(2);
    want[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6; rr[0] = 10;
    want[1] = 128'he98ba06f448c773c8ecc720401002202; rr[1] = 12;
    want[2] = 128'hfe4890d1e6188d0b046df344706c631e; rr[2] = 14;
    for (int k = 0; k < 3; k++) begin
      read_one(k, rr[k], o, v, e);
      checks++;
      if (v !== 1'b1 || o !== want[k]) begin
        errors++;
        $display("FAIL last_round k=%0d: got valid=%b %h want %h", k, v, o, want[k]);
      end
      test_read_all(k);
    end
  endtask

  task automatic test_read_errors();
    logic [127:0] prev, o;
    logic [255:0] kv;
    logic v, e;
    int bad;
    prev = out_s[0];
    for (int n = 0; n < 2; n++) begin
      bad = (n == 0) ? 11 : int'($urandom_range(12, 15));
      read_one(0, bad, o, v, e);
      checks++;
      if (e !== 1'b1 || v !== 1'b0 || o !== prev) begin
        errors++;
        $display("FAIL bad_index idx=%0d: got err=%b valid=%b %h want err=1 valid=0 %h", bad, e, v, o, prev);
      end
      tick();
      checks++;
      if (err_s[0] !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse: got %b want 0", err_s[0]);
      end
    end
    kv = {rand_key()};
    kv[127:0] = '0;
    model_expand(0, kv);
    do_start(0, kv);
    repeat (5) tick();
    read_one(0, 0, o, v, e);
    checks++;
    if (e !== 1'b1 || v !== 1'b0 || o !== prev) begin
      errors++;
      $display("FAIL read_while_busy: got err=%b valid=%b %h want err=1 valid=0 %h", e, v, o, prev);
    end
    wait_ready(0);
    test_read_all(0);
  endtask

  task automatic test_ignore_start();
    logic [255:0] ka, kb;
    ka = rand_key(); ka[127:0] = '0;
    kb = rand_key();
    model_expand(0, ka);
    do_start(0, ka);
    while (ecnt - e0 < 10) tick();
    set_key(0, kb);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    wait_ready(0);
    test_read_all(0);
  endtask

  task automatic test_reset_mid_expand();
    logic [255:0] ka;
    logic seen;
    ka = rand_key(); ka[127:0] = '0;
    do_start(0, ka);
    while (ecnt - e0 < 19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy_s[0], ready_s[0], done_s[0], valid_s[0], err_s[0], out_s[0]} !== '0) begin
      errors++;
      $display("FAIL mid_expand_reset: got busy=%b ready=%b done=%b valid=%b err=%b out=%h want all 0",
               busy_s[0], ready_s[0], done_s[0], valid_s[0], err_s[0], out_s[0]);
    end
    seen = 1'b0;
    repeat (50) begin
      tick();
      seen = seen | busy_s[0] | ready_s[0] | done_s[0];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL stays_idle_after_reset: got activity=%b want 0", seen);
    end
    ka = rand_key(); ka[127:0] = '0;
    model_expand(0, ka);
    do_start(0, ka);
    wait_ready(0);
    test_read_all(0);
  endtask

  task automatic test_rekey_with_read();
    logic [255:0] kb;
    logic [127:0] old10;
    old10 = rk_model(0, 10);
    kb = rand_key(); kb[127:0] = '0;
    set_key(0, kb);
    start_s[0] = 1'b1;
    req_s[0]   = 1'b1;
    idx_s[0]   = 4'd10;
    tick();
    start_s[0] = 1'b0;
    req_s[0]   = 1'b0;
    e0 = ecnt;
    checks++;
    if (valid_s[0] !== 1'b1 || out_s[0] !== old10 || ready_s[0] !== 1'b0 || busy_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL rekey_read: got valid=%b ready=%b busy=%b %h want valid=1 ready=0 busy=1 %h",
               valid_s[0], ready_s[0], busy_s[0], out_s[0], old10);
    end
    model_expand(0, kb);
    wait_ready(0);
    test_read_all(0);
  endtask

  task automatic test_back_to_back();
    logic [255:0] kv;
    for (int k = 0; k < 3; k++) begin
      repeat (2) begin
        kv = rand_key();
        model_expand(k, kv);
        do_start(k, kv);
        wait_ready(k);
        test_read_all(k);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    key4 = '0;
    key6 = '0;
    key8 = '0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      req_s[k]   = 1'b0;
      idx_s[k]   = 4'd0;
    end
    build_sbox();
    test_reset();
    test_known_vectors();
    test_read_errors();
    test_ignore_start();
    test_reset_mid_expand();
    test_rekey_with_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
